reg_bank_param: RTL and testbench

Parametrised register bank for the CPU datapath: N registers of W bits, each loaded from the shared bus under a one-hot select. It adds synchronous reset, two registered read ports with write-through bypass, per-register dirty tracking and one-hot select error detection to the fixed 8×16 bank. It sits between the bus and the ALU/operand muxes.

---
 rtl/reg_bank_pkg.sv | 22 ++
 rtl/reg_word.sv | 17 +
 rtl/reg_bank_param.sv | 79 +++++++
 tb/tb_reg_bank_param.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared limits and one-hot select helpers for the parametrised register bank.
package reg_bank_pkg;

   localparam int N_MAX = 32;
   localparam int W_MAX = 64;
   localparam int IDX_W = $clog2(N_MAX);

   // A write is valid only when exactly one select bit is set.
   function automatic logic is_onehot(input logic [N_MAX-1:0] sel);
      return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
   endfunction

   function automatic logic [IDX_W-1:0] onehot_idx(input logic [N_MAX-1:0] sel);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_MAX; i++) begin
         if (sel[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/reg_word.sv
// Single W-bit register with synchronous active-low reset and load enable.
module reg_word #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n) q <= '0;
      else if (ena) q <= d;
   end

endmodule

// File: rtl/reg_bank_param.sv
// N x W register bank: one-hot bus writes, two registered read ports with
// write-through bypass, per-register dirty flags and sticky select error.
module reg_bank_param
   import reg_bank_pkg::*;
#(
   parameter  int N  = 8,
   parameter  int W  = 16,
   localparam int AW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   reg_sel,
   input  logic [W-1:0]   bus,
   input  logic [AW-1:0]  rd_addr_a,
   input  logic [AW-1:0]  rd_addr_b,
   output logic [W-1:0]   rd_data_a,
   output logic [W-1:0]   rd_data_b,
   output logic [N*W-1:0] q_flat,
   output logic [N-1:0]   dirty,
   input  logic [N-1:0]   dirty_clr,
   output logic           sel_err
);

   logic [N_MAX-1:0] sel_ext;
   logic             wr_ok;
   logic [IDX_W-1:0] wr_idx;
   logic [W-1:0]     q [N];
   logic [W-1:0]     rd_nxt_a;
   logic [W-1:0]     rd_nxt_b;

   assign sel_ext = N_MAX'(reg_sel);
   assign wr_ok   = is_onehot(sel_ext);
   assign wr_idx  = onehot_idx(sel_ext);

   for (genvar i = 0; i < N; i++) begin : g_word
      reg_word #(.W(W)) u_word (
         .clk   (clk),
         .rst_n (rst_n),
         .ena   (reg_sel[i] & wr_ok),
         .d     (bus),
         .q     (q_flat[i*W +: W])
      );
      assign q[i] = q_flat[i*W +: W];
   end

   // Addresses at or beyond N match no register and read back as zero.
   always_comb begin
      rd_nxt_a = '0;
      rd_nxt_b = '0;
      for (int i = 0; i < N; i++) begin
         if (rd_addr_a == AW'(i)) rd_nxt_a = q[i];
         if (rd_addr_b == AW'(i)) rd_nxt_b = q[i];
      end
      if (wr_ok && (32'(rd_addr_a) == 32'(wr_idx))) rd_nxt_a = bus;
      if (wr_ok && (32'(rd_addr_b) == 32'(wr_idx))) rd_nxt_b = bus;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else begin
         rd_data_a <= rd_nxt_a;
         rd_data_b <= rd_nxt_b;
      end
   end

   // A write and a clear on the same register in one cycle leaves it dirty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dirty   <= '0;
         sel_err <= 1'b0;
      end else begin
         dirty <= (dirty & ~dirty_clr) | (wr_ok ? reg_sel : '0);
         if ((reg_sel != '0) && !wr_ok) sel_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_bank_param.sv
// Scoreboard bench for reg_bank_param: default 8x16 bank plus a 5x8 instance.
module tb_reg_bank_param;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   reg_sel, dirty_clr, dirty;
   logic [15:0]  bus, rd_data_a, rd_data_b;
   logic [2:0]   rd_addr_a, rd_addr_b;
   logic [127:0] q_flat;
   logic         sel_err;

   logic [4:0]   reg_sel2, dirty2;
   logic [7:0]   bus2, rd_data_a2, rd_data_b2;
   logic [2:0]   rd_addr_a2, rd_addr_b2;
   logic [39:0]  q_flat2;
   logic         sel_err2;

   always #5 clk = ~clk;

   reg_bank_param dut (
      .clk(clk), .rst_n(rst_n), .reg_sel(reg_sel), .bus(bus),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .q_flat(q_flat), .dirty(dirty), .dirty_clr(dirty_clr), .sel_err(sel_err)
   );

   reg_bank_param #(.N(5), .W(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .reg_sel(reg_sel2), .bus(bus2),
      .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2),
      .rd_data_a(rd_data_a2), .rd_data_b(rd_data_b2),
      .q_flat(q_flat2), .dirty(dirty2), .dirty_clr(5'h00), .sel_err(sel_err2)
   );

   typedef struct {
      int           due;
      int           kind;
      logic [127:0] exp;
      string        name;
   } sb_t;

   sb_t sb[$];
   int  cyc = 0;
   int  n_chk = 0;
   int  errors = 0;
   logic [15:0] mdl [8];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] actual(input int kind);
      case (kind)
         0: return q_flat;
         1: return 128'(rd_data_a);
         2: return 128'(rd_data_b);
         3: return 128'(dirty);
         4: return 128'(sel_err);
         5: return 128'(q_flat2);
         6: return 128'(rd_data_a2);
         7: return 128'(rd_data_b2);
         default: return 128'(dirty2);
      endcase
   endfunction

   function automatic logic [127:0] mdl_flat();
      logic [127:0] f;
      for (int i = 0; i < 8; i++) f[i*16 +: 16] = mdl[i];
      return f;
   endfunction

   // Monitor: compares every entry whose due cycle has arrived.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         automatic sb_t e = sb.pop_front();
         automatic logic [127:0] a = actual(e.kind);
         n_chk++;
         if (a !== e.exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", e.name, a, e.exp);
         end
      end
   end

   task automatic expect_at(input int dly, input int kind, input logic [127:0] v,
                            input string nm);
      sb_t e;
      e.due = cyc + dly; e.kind = kind; e.exp = v; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int idx, input logic [15:0] v);
      reg_sel = 8'(1 << idx);
      bus     = v;
      mdl[idx] = v;
      step();
      reg_sel = 8'h00;
   endtask

   initial begin
      rst_n = 1'b0; reg_sel = 8'hFF; bus = 16'hFFFF; dirty_clr = 8'h00;
      rd_addr_a = 3'd0; rd_addr_b = 3'd0;
      reg_sel2 = 5'h1F; bus2 = 8'hFF; rd_addr_a2 = 3'd0; rd_addr_b2 = 3'd0;
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
      step(); step();

      expect_at(0, 0, 128'h0, "reset_q_flat");
      expect_at(0, 1, 128'h0, "reset_rd_a");
      expect_at(0, 2, 128'h0, "reset_rd_b");
      expect_at(0, 3, 128'h0, "reset_dirty");
      expect_at(0, 4, 128'h0, "reset_sel_err");
      expect_at(0, 5, 128'h0, "reset_q_flat2");
      rst_n = 1'b1; reg_sel = 8'h00; reg_sel2 = 5'h00;
      step();

      // Small instance: out-of-range read and register 4 write with bypass.
      reg_sel2 = 5'h10; bus2 = 8'h7E; rd_addr_a2 = 3'd6; rd_addr_b2 = 3'd4;
      expect_at(1, 6, 128'h0, "n5_rd_a_oob");
      expect_at(1, 7, 128'h7E, "n5_rd_b_bypass");
      expect_at(1, 5, {88'h0, 8'h7E, 32'h0}, "n5_q_flat");
      expect_at(1, 8, 128'h10, "n5_dirty");
      step();
      reg_sel2 = 5'h00;

      for (int i = 0; i < 8; i++) wr(i, 16'h1000 + 16'(i));
      expect_at(0, 0, mdl_flat(), "wr_q_flat");
      expect_at(0, 3, 128'hFF, "wr_dirty");
      for (int k = 0; k < 8; k++) begin
         rd_addr_a = 3'(k);
         rd_addr_b = 3'(7 - k);
         expect_at(1, 1, 128'(16'h1000 + 16'(k)), $sformatf("sweep_a%0d", k));
         expect_at(1, 2, 128'(16'h1007 - 16'(k)), $sformatf("sweep_b%0d", k));
         step();
      end

      wr(3, 16'hAAAA);
      reg_sel = 8'h08; bus = 16'h5555; rd_addr_a = 3'd3; rd_addr_b = 3'd2;
      mdl[3] = 16'h5555;
      expect_at(1, 1, 128'h5555, "bypass_a");
      expect_at(1, 2, 128'h1002, "bypass_b_old");
      expect_at(1, 0, mdl_flat(), "bypass_q_flat");
      step();
      reg_sel = 8'h00;

      dirty_clr = 8'hFF;
      expect_at(1, 3, 128'h0, "dirty_clear");
      step();
      dirty_clr = 8'h00;

      reg_sel = 8'h05; bus = 16'hDEAD; rd_addr_a = 3'd0; rd_addr_b = 3'd2;
      expect_at(1, 1, 128'h1000, "multihot_no_bypass_a");
      expect_at(1, 2, 128'h1002, "multihot_no_bypass_b");
      expect_at(1, 0, mdl_flat(), "multihot_q_flat");
      expect_at(1, 4, 128'h1, "multihot_sel_err");
      expect_at(1, 3, 128'h0, "multihot_dirty");
      step();
      reg_sel = 8'h00;

      wr(1, 16'h1111);
      expect_at(0, 4, 128'h1, "sel_err_sticky");
      expect_at(0, 3, 128'h02, "dirty_after_write");
      expect_at(0, 0, mdl_flat(), "q_flat_after_write");

      wr(4, 16'h4444);
      wr(2, 16'h2222);
      expect_at(0, 3, 128'h16, "dirty_pre_race");
      dirty_clr = 8'h14; reg_sel = 8'h10; bus = 16'h4040; mdl[4] = 16'h4040;
      expect_at(1, 3, 128'h12, "dirty_race");
      expect_at(1, 0, mdl_flat(), "race_q_flat");
      step();
      dirty_clr = 8'h00; reg_sel = 8'h00;

      rst_n = 1'b0; reg_sel = 8'h02; bus = 16'hBEEF;
      expect_at(1, 0, 128'h0, "rst2_q_flat");
      expect_at(1, 3, 128'h0, "rst2_dirty");
      expect_at(1, 4, 128'h0, "rst2_sel_err");
      expect_at(1, 1, 128'h0, "rst2_rd_a");
      step();
      rst_n = 1'b1; reg_sel = 8'h00;

      step(); step(); step();
      if (sb.size() > 0) begin
         n_chk += sb.size();
         errors += sb.size();
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
